// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with per-register busy scoreboard.
// Two write-back ports (wb1 wins on a shared address), NRD combinational
// read ports with optional same-cycle bypass, optional hardwired-zero r0.
// After reset the array is cleared by a one-register-per-cycle sweep, so
// the storage has no reset and can map onto RAM.
//
// state | meaning
// INIT  | sweeping zeros into the array, ports ignored, reads return 0
// RUN   | normal operation
module regfile_mp_sb #(
  parameter int XLEN     = 64,
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                CLK,
  input  logic                reset,
  output logic                init_done,
  input  logic                issue_v,
  input  logic [AW-1:0]       issue_dr,
  input  logic                flush,
  input  logic                wb0_v,
  input  logic [AW-1:0]       wb0_dr,
  input  logic [XLEN-1:0]     wb0_data,
  input  logic                wb1_v,
  input  logic [AW-1:0]       wb1_dr,
  input  logic [XLEN-1:0]     wb1_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy
);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  localparam logic ZR = (ZERO_REG != 0);
  localparam logic BP = (BYPASS != 0);

  state_t            state;
  state_t            state_nxt;
  logic [AW-1:0]     cnt;
  logic [NREG-1:0]   busy;
  logic [XLEN-1:0]   mem [NREG];
  logic              wb0_en;
  logic              wb1_en;

  // Writes to r0 are dropped entirely when r0 is hardwired to zero.
  assign wb0_en = wb0_v && !(ZR && (wb0_dr == '0));
  assign wb1_en = wb1_v && !(ZR && (wb1_dr == '0));

  // init_done is simply "sweep finished", i.e. the registered RUN state.
  assign init_done = (state == RUN);

  // State register.
  always_ff @(posedge CLK) begin
    state <= state_nxt;
  end

  // Next-state: reset always restarts the sweep; INIT ends on the last register.
  always_comb begin
    state_nxt = state;
    if (reset) begin
      state_nxt = INIT;
    end else begin
      case (state)
        INIT:    if (cnt == AW'(NREG - 1)) state_nxt = RUN;
        RUN:     state_nxt = RUN;
        default: state_nxt = INIT;
      endcase
    end
  end

  // Sweep address counter.
  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt <= '0;
    end else if (state == INIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Array storage: sweep writes in INIT, write-back ports in RUN (wb1 last so it wins).
  always_ff @(posedge CLK) begin
    if (!reset) begin
      if (state == INIT) begin
        mem[cnt] <= '0;
      end else begin
        if (wb0_en) mem[wb0_dr] <= wb0_data;
        if (wb1_en) mem[wb1_dr] <= wb1_data;
      end
    end
  end

  // Scoreboard: flush, then issue set, then write-back clear, else hold.
  always_ff @(posedge CLK) begin
    if (reset) begin
      busy <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < NREG; i++) begin
        if (flush) begin
          busy[i] <= 1'b0;
        end else if (issue_v && (issue_dr == AW'(i)) && !(ZR && (i == 0))) begin
          busy[i] <= 1'b1;
        end else if ((wb0_v && (wb0_dr == AW'(i))) || (wb1_v && (wb1_dr == AW'(i)))) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  // Combinational read ports with optional forwarding of this cycle's write-backs.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    if (state == RUN) begin
      for (int k = 0; k < NRD; k++) begin
        rd_data[k*XLEN +: XLEN] = mem[rd_addr[k*AW +: AW]];
        rd_busy[k]              = busy[rd_addr[k*AW +: AW]];
        if (BP && wb0_v && (wb0_dr == rd_addr[k*AW +: AW])) begin
          rd_data[k*XLEN +: XLEN] = wb0_data;
          rd_busy[k]              = 1'b0;
        end
        if (BP && wb1_v && (wb1_dr == rd_addr[k*AW +: AW])) begin
          rd_data[k*XLEN +: XLEN] = wb1_data;
          rd_busy[k]              = 1'b0;
        end
        if (ZR && (rd_addr[k*AW +: AW] == '0)) begin
          rd_data[k*XLEN +: XLEN] = '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: one bypassing and one non-bypassing
// instance share all inputs and are checked against hand-computed values.
module tb_regfile_mp_sb;

  logic         CLK = 1'b0;
  logic         reset;
  logic         issue_v, flush, wb0_v, wb1_v;
  logic [4:0]   issue_dr, wb0_dr, wb1_dr;
  logic [63:0]  wb0_data, wb1_data;
  logic [9:0]   rd_addr;
  logic [127:0] rd_data_b, rd_data_n;
  logic [1:0]   rd_busy_b, rd_busy_n;
  logic         init_done_b, init_done_n;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 CLK = ~CLK;

  regfile_mp_sb #(.BYPASS(1)) dut (
    .CLK(CLK), .reset(reset), .init_done(init_done_b),
    .issue_v(issue_v), .issue_dr(issue_dr), .flush(flush),
    .wb0_v(wb0_v), .wb0_dr(wb0_dr), .wb0_data(wb0_data),
    .wb1_v(wb1_v), .wb1_dr(wb1_dr), .wb1_data(wb1_data),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b)
  );

  regfile_mp_sb #(.BYPASS(0)) dut_nb (
    .CLK(CLK), .reset(reset), .init_done(init_done_n),
    .issue_v(issue_v), .issue_dr(issue_dr), .flush(flush),
    .wb0_v(wb0_v), .wb0_dr(wb0_dr), .wb0_data(wb0_data),
    .wb1_v(wb1_v), .wb1_dr(wb1_dr), .wb1_data(wb1_data),
    .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    issue_v = 0; flush = 0; wb0_v = 0; wb1_v = 0;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  // Counts cycles until both instances report init_done, bounded.
  task automatic wait_init(output int cyc);
    cyc = 0;
    while (!(init_done_b && init_done_n) && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    idle();
    issue_dr = 0; wb0_dr = 0; wb1_dr = 0; wb0_data = 0; wb1_data = 0;
    set_rd(0, 0);
    reset = 1;
    tick(); tick();
    chk("reset_init_done", {63'd0, init_done_b}, 64'd0);
    chk("reset_rd_busy", {62'd0, rd_busy_b}, 64'd0);
    chk("reset_rd_data", rd_data_b[63:0], 64'd0);
    reset = 0;

    // 1: sweep length and cleared array
    wait_init(n);
    chk("init_cycles", 64'(n), 64'd32);
    for (int r = 0; r < 32; r++) begin
      set_rd(5'(r), 5'(31 - r));
      #1;
      chk("sweep_rd0", rd_data_b[63:0], 64'd0);
      chk("sweep_rd1", rd_data_b[127:64], 64'd0);
      chk("sweep_busy", {62'd0, rd_busy_b}, 64'd0);
    end

    // 2: write r5 with same-cycle read
    wb0_v = 1; wb0_dr = 5; wb0_data = 64'h1234; set_rd(5, 0);
    #1;
    chk("byp_r5_same", rd_data_b[63:0], 64'h1234);
    chk("nobyp_r5_same", rd_data_n[63:0], 64'd0);
    tick(); idle(); #1;
    chk("byp_r5_next", rd_data_b[63:0], 64'h1234);
    chk("nobyp_r5_next", rd_data_n[63:0], 64'h1234);

    // 3: dual write same address, then write to r0
    wb0_v = 1; wb0_dr = 7; wb0_data = 64'hAA;
    wb1_v = 1; wb1_dr = 7; wb1_data = 64'hBB; set_rd(7, 5);
    #1;
    chk("byp_r7_same", rd_data_b[63:0], 64'hBB);
    tick(); idle(); #1;
    chk("byp_r7", rd_data_b[63:0], 64'hBB);
    chk("nobyp_r7", rd_data_n[63:0], 64'hBB);
    chk("r5_port1", rd_data_b[127:64], 64'h1234);
    wb0_v = 1; wb0_dr = 0; wb0_data = 64'hFF; set_rd(0, 0);
    #1;
    chk("byp_r0_same", rd_data_b[63:0], 64'd0);
    tick(); idle(); #1;
    chk("byp_r0", rd_data_b[63:0], 64'd0);
    chk("nobyp_r0", rd_data_n[63:0], 64'd0);

    // 4: scoreboard set/clear
    issue_v = 1; issue_dr = 3; set_rd(0, 3);
    #1;
    chk("issue_same_busy", {63'd0, rd_busy_b[1]}, 64'd0);
    tick(); idle(); #1;
    chk("issue_busy_b", {63'd0, rd_busy_b[1]}, 64'd1);
    chk("issue_busy_n", {63'd0, rd_busy_n[1]}, 64'd1);
    wb1_v = 1; wb1_dr = 3; wb1_data = 64'h33;
    #1;
    chk("wb_clr_same_b", {63'd0, rd_busy_b[1]}, 64'd0);
    chk("wb_clr_same_n", {63'd0, rd_busy_n[1]}, 64'd1);
    tick(); idle(); #1;
    chk("wb_clr_next_b", {63'd0, rd_busy_b[1]}, 64'd0);
    chk("wb_clr_next_n", {63'd0, rd_busy_n[1]}, 64'd0);
    chk("r3_data", rd_data_n[127:64], 64'h33);
    issue_v = 1; issue_dr = 3; wb0_v = 1; wb0_dr = 3; wb0_data = 64'h44;
    tick(); idle(); #1;
    chk("set_beats_clr_b", {63'd0, rd_busy_b[1]}, 64'd1);
    chk("set_beats_clr_n", {63'd0, rd_busy_n[1]}, 64'd1);

    // 5: flush beats a same-cycle issue
    issue_v = 1; issue_dr = 1; tick();
    issue_dr = 2; tick();
    issue_dr = 9; tick(); idle();
    set_rd(1, 9); #1;
    chk("pre_flush_busy", {62'd0, rd_busy_b}, 64'd3);
    flush = 1; issue_v = 1; issue_dr = 4;
    tick(); idle(); #1;
    chk("flush_r1_r9", {62'd0, rd_busy_b}, 64'd0);
    set_rd(2, 4); #1;
    chk("flush_r2_r4", {62'd0, rd_busy_b}, 64'd0);
    set_rd(3, 3); #1;
    chk("flush_r3", {62'd0, rd_busy_n}, 64'd0);

    // 6: reset mid-operation
    issue_v = 1; issue_dr = 3; tick(); idle();
    set_rd(5, 3); #1;
    chk("pre_rst_r5", rd_data_b[63:0], 64'h1234);
    chk("pre_rst_r3_busy", {63'd0, rd_busy_b[1]}, 64'd1);
    reset = 1; tick(); reset = 0;
    wb0_v = 1; wb0_dr = 5; wb0_data = 64'hDEAD;
    wb1_v = 1; wb1_dr = 3; wb1_data = 64'h77;
    #1;
    chk("rst_init_done", {62'd0, init_done_b, init_done_n}, 64'd0);
    chk("rst_rd_r5", rd_data_b[63:0], 64'd0);
    chk("rst_rd_r3", rd_data_b[127:64], 64'd0);
    chk("rst_busy", {62'd0, rd_busy_b}, 64'd0);
    wait_init(n);
    idle(); #1;
    chk("reinit_cycles", 64'(n), 64'd32);
    chk("post_rst_r5_b", rd_data_b[63:0], 64'd0);
    chk("post_rst_r5_n", rd_data_n[63:0], 64'd0);
    chk("post_rst_r3_data", rd_data_n[127:64], 64'd0);
    chk("post_rst_r3_busy", {62'd0, rd_busy_b[1], rd_busy_n[1]}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
